prim_onehot_demux: RTL and testbench

Registered one-hot demultiplexer: accepts one valid/ready stream and a one-hot destination select, and steers each beat to exactly one of `Outputs` valid/ready streams. It is the distribution-side counterpart of `prim_onehot_mux`, which gathers beats. It sits between a single producer and a set of consumers, for example a request fan-out to several register/FIFO slots. A single buffer stage holds each beat until the selected consumer takes it, with full throughput when that consumer is always ready.

---
 rtl/prim_onehot_demux_pkg.sv | 19 +
 rtl/prim_onehot_check.sv | 26 ++
 rtl/prim_onehot_demux.sv | 141 ++++++++++++++
 tb/tb_prim_onehot_demux.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_onehot_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prim_onehot_demux_pkg
// Brief    : Shared types and constants for the registered one-hot demux.
// Revision : 1.0 - initial release
// ============================================================================
package prim_onehot_demux_pkg;

    // Buffer occupancy: the single holding stage is either empty or full.
    typedef enum logic [0:0] {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } demux_state_e;

    // Width of the saturating dropped-beat counter.
    localparam int unsigned ErrCntWidth = 8;

endpackage : prim_onehot_demux_pkg
`default_nettype wire

// File: rtl/prim_onehot_check.sv
`default_nettype none
// ============================================================================
// Module   : prim_onehot_check
// Brief    : Classifies a select vector (zero / one-hot) and isolates its
//            lowest set bit. Purely combinational, reusable by mux callers.
// Revision : 1.0 - initial release
// ============================================================================
module prim_onehot_check #(
    parameter int unsigned Width = 8
) (
    input  logic [Width-1:0] vec_i,
    output logic             is_onehot_o,
    output logic             is_zero_o,
    output logic [Width-1:0] lowest_onehot_o
);

    localparam logic [Width-1:0] One = {{(Width-1){1'b0}}, 1'b1};

    assign is_zero_o       = (vec_i == '0);
    // Clearing the lowest set bit leaves nothing only when exactly one was set.
    assign is_onehot_o     = !is_zero_o && ((vec_i & (vec_i - One)) == '0);
    // Two's-complement trick: v & -v keeps only the lowest set bit.
    assign lowest_onehot_o = vec_i & (~vec_i + One);

endmodule : prim_onehot_check
`default_nettype wire

// File: rtl/prim_onehot_demux.sv
`default_nettype none
// ============================================================================
// Module   : prim_onehot_demux
// Brief    : Registered one-hot demultiplexer. One valid/ready input stream
//            is steered through a single buffer stage to one of Outputs
//            valid/ready streams chosen by a one-hot select.
//            Optional feature macro: PRIM_ONEHOT_DEMUX_ERR_EN (drop and count
//            zero/multi-hot selects; otherwise multi-hot is reduced to its
//            lowest bit and zero is silently dropped).
// Revision : 1.0 - initial release
// ============================================================================
module prim_onehot_demux
    import prim_onehot_demux_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned Outputs = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [Width-1:0]       in_data_i,
    input  logic [Outputs-1:0]     sel_i,
    output logic [Outputs-1:0]     out_valid_o,
    input  logic [Outputs-1:0]     out_ready_i,
    output logic [Width-1:0]       out_data_o,
    output logic                   err_o,
    output logic [ErrCntWidth-1:0] err_cnt_o
);

    demux_state_e       state_q, state_d;
    logic [Width-1:0]   data_q, data_d;
    logic [Outputs-1:0] sel_q, sel_d;

    logic               sel_is_onehot;
    logic               sel_is_zero;
    logic [Outputs-1:0] sel_lowest;
    logic [Outputs-1:0] load_sel;
    logic               sel_legal;
    logic               in_xfer;
    logic               out_xfer;
    logic               load_en;

    prim_onehot_check #(
        .Width (Outputs)
    ) u_sel_check (
        .vec_i           (sel_i),
        .is_onehot_o     (sel_is_onehot),
        .is_zero_o       (sel_is_zero),
        .lowest_onehot_o (sel_lowest)
    );

`ifdef PRIM_ONEHOT_DEMUX_ERR_EN
    // Only a strictly one-hot select is loadable; anything else is dropped.
    assign sel_legal = sel_is_onehot && !sel_is_zero;
    assign load_sel  = sel_lowest;
`else
    // Multi-hot collapses to its lowest bit; only an all-zero select drops.
    assign sel_legal = !sel_is_zero;
    assign load_sel  = sel_is_onehot ? sel_i : sel_lowest;
`endif

    // Pass-through ready: a new beat may enter while the held one drains.
    assign in_ready_o  = (state_q == StEmpty) || (|(sel_q & out_ready_i));
    assign out_valid_o = (state_q == StFull) ? sel_q : '0;
    assign out_data_o  = data_q;

    assign in_xfer  = in_valid_i && in_ready_o;
    assign out_xfer = |(out_valid_o & out_ready_i);
    assign load_en  = in_xfer && sel_legal;

    // Holding-stage registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StEmpty;
            data_q  <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state: load on a legal accept, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        case (state_q)
            StEmpty: begin
                if (load_en) begin
                    state_d = StFull;
                    data_d  = in_data_i;
                    sel_d   = load_sel;
                end
            end
            StFull: begin
                if (out_xfer) begin
                    if (load_en) begin
                        data_d = in_data_i;
                        sel_d  = load_sel;
                    end else begin
                        state_d = StEmpty;
                    end
                end
            end
            default: state_d = StEmpty;
        endcase
    end

`ifdef PRIM_ONEHOT_DEMUX_ERR_EN
    localparam logic [ErrCntWidth-1:0] CntOne = {{(ErrCntWidth-1){1'b0}}, 1'b1};

    logic                   drop;
    logic                   err_q;
    logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

    assign drop      = in_xfer && !sel_legal;
    assign err_cnt_d = (drop && (err_cnt_q != '1)) ? (err_cnt_q + CntOne) : err_cnt_q;

    // Error pulse and saturating drop counter, both one cycle after the drop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q     <= drop;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
`else
    assign err_o     = 1'b0;
    assign err_cnt_o = '0;
`endif

endmodule : prim_onehot_demux
`default_nettype wire

// File: tb/tb_prim_onehot_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_onehot_demux
// Brief    : Directed self-checking bench for prim_onehot_demux with an
//            in-order scoreboard of accepted beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prim_onehot_demux;

    localparam int unsigned W = 32;
    localparam int unsigned N = 8;

    typedef struct packed {
        logic [N-1:0] sel;
        logic [W-1:0] data;
    } beat_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] in_data_i;
    logic [N-1:0] sel_i;
    logic [N-1:0] out_valid_o;
    logic [N-1:0] out_ready_i;
    logic [W-1:0] out_data_o;
    logic         err_o;
    logic [7:0]   err_cnt_o;

    int checks = 0;
    int errors = 0;
    beat_t sb[$];

    prim_onehot_demux #(
        .Width   (W),
        .Outputs (N)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .sel_i       (sel_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .err_o       (err_o),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected destination for a select, or zero when the beat is dropped.
    function automatic logic [N-1:0] exp_sel(input logic [N-1:0] s);
        logic [N-1:0] r;
        int ones;
        r = '0;
        ones = 0;
        for (int i = 0; i < N; i++) if (s[i]) ones++;
`ifdef PRIM_ONEHOT_DEMUX_ERR_EN
        if (ones == 1) r = s;
`else
        for (int i = N - 1; i >= 0; i--) if (s[i]) r = '0 | (N'(1) << i);
`endif
        return r;
    endfunction

    // Negedge: pop the drained beat and compare, then record any new accept.
    task automatic sample();
        beat_t b;
        @(negedge clk_i);
        if (|(out_valid_o & out_ready_i)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_out", {56'd0, out_valid_o}, 64'd0);
            end else begin
                b = sb.pop_front();
                check("sb_sel", {56'd0, out_valid_o}, {56'd0, b.sel});
                check("sb_data", {32'd0, out_data_o}, {32'd0, b.data});
            end
        end
        if (in_valid_i && in_ready_o && (exp_sel(sel_i) != '0)) begin
            b.sel  = exp_sel(sel_i);
            b.data = in_data_i;
            sb.push_back(b);
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] s, input logic [W-1:0] d);
        in_valid_i = v;
        sel_i      = s;
        in_data_i  = d;
    endtask

    initial begin
        logic [N-1:0] sels [4];
        sels[0] = 8'h01; sels[1] = 8'h02; sels[2] = 8'h04; sels[3] = 8'h80;

        rst_i = 1'b1;
        drive(1'b0, '0, '0);
        out_ready_i = '0;
        adv(); adv();
        rst_i = 1'b0;

        // Reset state.
        sample();
        check("rst_out_valid", {56'd0, out_valid_o}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
        check("rst_out_data", {32'd0, out_data_o}, 64'd0);
        check("rst_err", {63'd0, err_o}, 64'd0);
        check("rst_err_cnt", {56'd0, err_cnt_o}, 64'd0);
        adv();

        // Back-to-back beats with every consumer ready: one cycle latency, no bubbles.
        out_ready_i = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, sels[k], 32'hA0 + k);
            sample();
            check("stream_in_ready", {63'd0, in_ready_o}, 64'd1);
            check("stream_latency", {56'd0, out_valid_o}, {56'd0, (k == 0) ? 8'h00 : sels[k-1]});
            adv();
        end
        drive(1'b0, '0, '0);
        sample();
        check("stream_last", {56'd0, out_valid_o}, 64'h80);
        adv();
        sample();
        check("stream_idle", {56'd0, out_valid_o}, 64'd0);
        adv();

        // Stall: held beat stays stable, extra beat is refused until drain.
        out_ready_i = 8'h00;
        drive(1'b1, 8'h04, 32'hDEADBEEF);
        sample();
        adv();
        drive(1'b1, 8'h01, 32'h11111111);
        for (int c = 0; c < 5; c++) begin
            sample();
            check("stall_valid", {56'd0, out_valid_o}, 64'h04);
            check("stall_data", {32'd0, out_data_o}, 64'hDEADBEEF);
            check("stall_in_ready", {63'd0, in_ready_o}, 64'd0);
            adv();
        end
        drive(1'b0, '0, '0);
        out_ready_i = 8'h04;
        sample();
        check("drain_in_ready", {63'd0, in_ready_o}, 64'd1);
        adv();
        out_ready_i = 8'h00;
        sample();
        check("drain_empty", {56'd0, out_valid_o}, 64'd0);
        adv();

        // Unselected readiness is ignored; selected ready allows same-cycle reload.
        drive(1'b1, 8'h01, 32'hC0);
        sample();
        adv();
        out_ready_i = 8'hFE;
        drive(1'b1, 8'h10, 32'hC1);
        for (int c = 0; c < 2; c++) begin
            sample();
            check("unsel_in_ready", {63'd0, in_ready_o}, 64'd0);
            check("unsel_valid", {56'd0, out_valid_o}, 64'h01);
            adv();
        end
        out_ready_i = 8'hFF;
        sample();
        check("reload_in_ready", {63'd0, in_ready_o}, 64'd1);
        adv();
        drive(1'b0, '0, '0);
        sample();
        check("reload_valid", {56'd0, out_valid_o}, 64'h10);
        check("reload_data", {32'd0, out_data_o}, 64'hC1);
        adv();

`ifdef PRIM_ONEHOT_DEMUX_ERR_EN
        // Illegal selects are consumed, flagged and counted.
        drive(1'b1, 8'h03, 32'hE1);
        sample();
        check("ill_in_ready0", {63'd0, in_ready_o}, 64'd1);
        adv();
        drive(1'b1, 8'h00, 32'hE2);
        sample();
        check("ill_err0", {63'd0, err_o}, 64'd1);
        check("ill_cnt1", {56'd0, err_cnt_o}, 64'd1);
        check("ill_valid0", {56'd0, out_valid_o}, 64'd0);
        adv();
        drive(1'b0, '0, '0);
        sample();
        check("ill_err1", {63'd0, err_o}, 64'd1);
        check("ill_cnt2", {56'd0, err_cnt_o}, 64'd2);
        check("ill_valid1", {56'd0, out_valid_o}, 64'd0);
        adv();
        sample();
        check("ill_err_clear", {63'd0, err_o}, 64'd0);
        adv();
        drive(1'b1, 8'hFF, 32'hE3);
        for (int c = 0; c < 300; c++) begin
            sample();
            adv();
        end
        drive(1'b0, '0, '0);
        sample();
        check("ill_sat", {56'd0, err_cnt_o}, 64'd255);
        check("ill_sat_valid", {56'd0, out_valid_o}, 64'd0);
        adv();
`else
        // Multi-hot reduces to lowest bit; zero select is dropped silently.
        drive(1'b1, 8'h0C, 32'hC2);
        sample();
        adv();
        drive(1'b1, 8'h00, 32'hC3);
        sample();
        check("multihot_valid", {56'd0, out_valid_o}, 64'h04);
        check("multihot_err", {63'd0, err_o}, 64'd0);
        adv();
        drive(1'b0, '0, '0);
        sample();
        check("zero_dropped", {56'd0, out_valid_o}, 64'd0);
        check("zero_err", {63'd0, err_o}, 64'd0);
        check("zero_err_cnt", {56'd0, err_cnt_o}, 64'd0);
        adv();
`endif

        // Reset while full discards the held beat.
        out_ready_i = 8'h00;
        drive(1'b1, 8'h20, 32'hE0);
        sample();
        adv();
        drive(1'b0, '0, '0);
        rst_i = 1'b1;
        sample();
        check("prerst_valid", {56'd0, out_valid_o}, 64'h20);
        adv();
        rst_i = 1'b0;
        sb.delete();
        out_ready_i = 8'hFF;
        sample();
        check("postrst_valid", {56'd0, out_valid_o}, 64'd0);
        check("postrst_in_ready", {63'd0, in_ready_o}, 64'd1);
        check("postrst_err_cnt", {56'd0, err_cnt_o}, 64'd0);
        adv();
        for (int c = 0; c < 3; c++) begin
            sample();
            check("postrst_no_deliver", {56'd0, out_valid_o}, 64'd0);
            adv();
        end

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule : tb_prim_onehot_demux
`default_nettype wire
